// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   WHB_*        access size encodings carried on req_whb / dm_whb
//   lsu_state_t  request FSM states
//   size_bytes   bytes touched by an access of a given size (2'b11 acts as word)
package lsu_pkg;
  localparam logic [1:0] WHB_WORD = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_BYTE = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] whb);
    case (whb)
      WHB_HALF: return 3'd2;
      WHB_BYTE: return 3'd1;
      default:  return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/lsu_split_if.sv
// lsu_split_if: request/response handshake from the MEM stage plus the dmem bus.
//   slave  : LSU view (consumes requests, drives response and dmem controls)
//   master : pipeline + memory view (drives requests and dm_rd)
interface lsu_split_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [1:0]           req_whb;
  logic                 req_unsigned;
  logic [ADDR_SIZE-1:0] req_pc;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 dm_we;
  logic [XLEN-1:0]      dm_a;
  logic [XLEN-1:0]      dm_wd;
  logic [ADDR_SIZE-1:0] dm_pc;
  logic [1:0]           dm_whb;
  logic                 dm_lunsigned;
  logic [XLEN-1:0]      dm_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_whb, req_unsigned, req_pc, dm_rd,
    output req_ready, resp_valid, resp_rdata,
           dm_we, dm_a, dm_wd, dm_pc, dm_whb, dm_lunsigned
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_whb, req_unsigned, req_pc, dm_rd,
    input  req_ready, resp_valid, resp_rdata,
           dm_we, dm_a, dm_wd, dm_pc, dm_whb, dm_lunsigned
  );
endinterface

// File: rtl/lsu_split_load_ext.sv
// load_ext: pick the addressed lane out of a raw word and sign/zero extend it.
//   data_i     raw word (or LSB-justified assembled bytes with off_i = 0)
//   off_i      byte offset of the access; halfwords only use off_i[1]
//   whb_i      access size, unsigned_i selects zero extension
//   data_o     XLEN-wide load result
module load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      whb_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [1:0]      off;
  logic [XLEN-1:0] sh;

  always_comb begin
    off = (whb_i == WHB_HALF) ? {off_i[1], 1'b0} : off_i;
    sh  = data_i >> {off, 3'b000};
    case (whb_i)
      WHB_HALF: data_o = unsigned_i ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                    : {{(XLEN-16){sh[15]}}, sh[15:0]};
      WHB_BYTE: data_o = unsigned_i ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                    : {{(XLEN-8){sh[7]}}, sh[7:0]};
      default:  data_o = data_i;
    endcase
  end
endmodule

// File: rtl/lsu_split.sv
// lsu_split: single-outstanding load/store unit between MEM and dmem.
// Aligned requests make one dmem access; misaligned half/word requests are
// split into sequential byte accesses. Completion is a one-cycle resp_valid.
//   clk, reset    clock, synchronous active-high reset
//   bus           lsu_split_if.slave (request, response, dmem bus)
//   misalign_cnt  saturating count of accepted misaligned requests
module lsu_split
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  lsu_split_if.slave  bus,
  output logic [15:0] misalign_cnt
);
  lsu_state_t           state_q;
  logic                 we_q, uns_q, mis_q;
  logic [XLEN-1:0]      addr_q, wdata_q, buf_q;
  logic [1:0]           whb_q, k_q, klast_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [15:0]          cnt_q;

  logic                 accept, req_mis, last;
  logic [2:0]           req_nb;
  logic [XLEN-1:0]      addr_k, ext_data;

  assign bus.req_ready = (state_q != ST_ACCESS);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_nb        = size_bytes(bus.req_whb);
  assign req_mis       = (req_nb == 3'd2 && bus.req_addr[0]) ||
                         (req_nb == 3'd4 && bus.req_addr[1:0] != 2'b00);
  assign last          = !mis_q || (k_q == klast_q);
  assign addr_k        = addr_q + XLEN'(k_q);   // wraps mod 2^XLEN

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      whb_q   <= 2'b00;
      k_q     <= 2'b00;
      klast_q <= 2'b00;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_ACCESS: begin
          if (!we_q) begin
            if (mis_q) buf_q[{k_q, 3'b000} +: 8] <= bus.dm_rd[{bus.dm_a[1:0], 3'b000} +: 8];
            else       buf_q <= bus.dm_rd;
          end
          if (last) state_q <= ST_DONE;
          else      k_q     <= k_q + 2'd1;
        end
        default: state_q <= accept ? ST_ACCESS : ST_IDLE;
      endcase
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        whb_q   <= bus.req_whb;
        pc_q    <= bus.req_pc;
        mis_q   <= req_mis;
        klast_q <= 2'(req_nb - 3'd1);
        k_q     <= 2'b00;
        buf_q   <= '0;
        if (req_mis && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Assembled misaligned bytes are already LSB-justified, so no lane offset.
  load_ext #(.XLEN(XLEN)) u_ext (
    .data_i     (buf_q),
    .off_i      (mis_q ? 2'b00 : addr_q[1:0]),
    .whb_i      (whb_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign bus.resp_valid   = (state_q == ST_DONE);
  assign bus.resp_rdata   = (state_q == ST_DONE && !we_q) ? ext_data : '0;
  assign bus.dm_pc        = pc_q;
  assign bus.dm_lunsigned = uns_q;
  assign misalign_cnt     = cnt_q;

  always_comb begin
    bus.dm_we  = 1'b0;
    bus.dm_a   = '0;
    bus.dm_wd  = '0;
    bus.dm_whb = 2'b00;
    if (state_q == ST_ACCESS) begin
      bus.dm_we = we_q;
      if (mis_q) begin
        bus.dm_a        = addr_k;
        bus.dm_whb      = WHB_BYTE;
        bus.dm_wd[7:0]  = wdata_q[{k_q, 3'b000} +: 8];
      end else begin
        bus.dm_a   = addr_q;
        bus.dm_whb = whb_q;
        bus.dm_wd  = wdata_q;
      end
    end
  end
endmodule

// File: doc/lsu_split.md
# lsu_split

Load/store unit between the MEM pipeline stage and the data memory `dmem`. It accepts one memory request at a time over a valid/ready handshake. Aligned requests are forwarded to `dmem` as a single access. Misaligned halfword or word requests are split into sequential byte accesses. Load results are returned as sign- or zero-extended words on a one-cycle response pulse.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `ADDR_SIZE`, 32, address width.

Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `reset`).

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  `XLEN`  byte address.
- `req_wdata`  in  `XLEN`  store data, LSB-justified.
- `req_whb`  in  2  size: 2'b00 word, 2'b01 half, 2'b10 byte; 2'b11 is treated as word.
- `req_unsigned`  in  1  zero-extend the load result.
- `req_pc`  in  `ADDR_SIZE`  PC of the instruction, for the memory trace.
- `resp_valid`  out  1  one-cycle pulse when the request completes; pulses for loads and stores.
- `resp_rdata`  out  `XLEN`  extended load data; 0 for stores.
- `misalign_cnt`  out  16  count of misaligned requests accepted; saturates at 16'hFFFF.
- `dm_we`, `dm_a`, `dm_wd`, `dm_pc`, `dm_whb`, `dm_lunsigned`  out  1/`XLEN`/`XLEN`/`ADDR_SIZE`/2/1  drive the corresponding `dmem` inputs.
- `dm_rd`  in  `XLEN`  raw word from `dmem`; combinational read of `RAM[dm_a[11:2]]`.

## Operation
- States: IDLE, ACCESS, DONE.
- Accept: `req_ready` = 1 in IDLE and DONE, 0 in ACCESS. On `req_valid && req_ready`:
  - register all `req_*` fields;
  - compute `nbytes` (4/2/1);
  - set `mis` = (half && addr[0]) || (word && addr[1:0] != 0);
  - clear the byte index `k`;
  - go to ACCESS.
- ACCESS, aligned (`mis` = 0): one cycle.
  - `dm_a` = addr, `dm_whb` = whb, `dm_wd` = wdata, `dm_we` = we.
  - Load: capture `dm_rd` at the clock edge.
  - Go to DONE.
- ACCESS, misaligned: `nbytes` cycles, k = 0..nbytes-1.
  - `dm_a` = addr + k (mod 2^32), `dm_whb` = byte.
  - `dm_wd[7:0]` = wdata byte k, upper bits 0; `dm_we` = we.
  - Load: buffer byte k ← `dm_rd` lane (`dm_a[1:0]`).
  - After k = nbytes-1, go to DONE.
- Aligned load extraction: word → `dm_rd`. Half/byte → lane selected by addr[1:0] (half uses addr[1]), placed at bits [15:0]/[7:0].
- DONE:
  - `resp_valid` = 1.
  - `resp_rdata` = captured data sign-extended from bit 7 (byte) or bit 15 (half), or zero-extended if `unsigned`; word passes through.
  - Go to IDLE, or to ACCESS if a new request is accepted in the same cycle.
- `dm_we` = 0 and `dm_whb` = 2'b00 outside ACCESS. `dm_pc` = registered pc. `dm_lunsigned` = registered unsigned.
- `misalign_cnt` increments on acceptance of a misaligned request and saturates at 16'hFFFF.

## Timing
- Reset: state IDLE.
  - `req_ready` = 1 after reset deasserts.
  - `resp_valid` = 0, `resp_rdata` = 0, `misalign_cnt` = 0.
  - All `dm_*` outputs = 0.
- Accept at cycle T:
  - aligned: `dmem` access at T+1, `resp_valid` at T+2;
  - misaligned: accesses at T+1..T+nbytes, `resp_valid` at T+nbytes+1.
- Back-to-back: a request accepted in DONE starts ACCESS the next cycle. Sustained aligned throughput is one request per 2 cycles.
- Reset mid-ACCESS: the next cycle is IDLE with `dm_we` = 0. Byte stores already committed remain in memory; no response is issued.
- `req_*` inputs are sampled only at acceptance; later changes have no effect.
- Address 0xFFFFFFFD, word: bytes go to 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.

## Structure
- Package `lsu_pkg`:
  - size encodings `WHB_WORD`, `WHB_HALF`, `WHB_BYTE`;
  - state enum `lsu_state_t`;
  - function `size_bytes(whb)`.
- Sub-module `load_ext`: combinational extraction and extension of {data, whb, unsigned} → `XLEN` word; shared with any future load path.
- Top level holds the FSM, the byte index `k`, the load assembly buffer and the counter.

## Test plan
- Aligned store word 0xDEADBEEF at 0x100, then load word from 0x100 → `dmem` accesses at T+1, `resp_valid` at T+2, `resp_rdata` = 0xDEADBEEF.
- Preload word 0x000080FF at 0x200.
  - lb 0x200 → 0xFFFFFFFF.
  - lbu 0x200 → 0x000000FF.
  - lh 0x200 → 0xFFFF80FF.
  - lhu 0x200 → 0x000080FF.
- Misaligned sw 0x11223344 at 0x103 → 4 byte writes at 0x103..0x106. Word 0x100 byte 3 = 0x44, word 0x104 = 0x??112233 (upper byte unchanged). `resp_valid` at T+5; `misalign_cnt` = 1.
- Misaligned lh at 0x1FF, with bytes 0x80 at 0x1FF and 0x12 at 0x200 → 2 accesses, `resp_rdata` = 0x00001280.
- Back-to-back: a new request held valid during DONE is accepted that cycle; its ACCESS follows the next cycle with no IDLE bubble.
- Reset asserted during the 3rd byte of a misaligned sw → no `dm_we` after the reset edge, no `resp_valid`, `req_ready` = 1 after reset deasserts, `misalign_cnt` = 0.
